// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU,
//            MTHI/MTLO). Optional single-cycle multiplier: MULDIV_FAST_MUL_EN.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divByZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               dbz_q;

    // Operand magnitudes; only the signed ops (op[0]==0) strip the sign.
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign a_neg = ~op[0] & srcA[WIDTH-1];
    assign b_neg = ~op[0] & srcB[WIDTH-1];
    assign a_mag = a_neg ? -srcA : srcA;
    assign b_mag = b_neg ? -srcB : srcB;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_step_d;
    logic [2*WIDTH-1:0] div_step_d;

    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
    assign mul_step_d = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, b_q};
    assign div_step_d = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    logic [WIDTH-1:0] hi_res_d;
    logic [WIDTH-1:0] lo_res_d;
    logic             dbz_d;

    always_comb begin
        hi_res_d = acc_q[2*WIDTH-1:WIDTH];
        lo_res_d = acc_q[WIDTH-1:0];
        dbz_d    = 1'b0;
        if (!op_q[1]) begin
            if (!op_q[0] && (sign_a_q ^ sign_b_q)) begin
                {hi_res_d, lo_res_d} = -acc_q;
            end
        end else if (b_q == {WIDTH{1'b0}}) begin
            hi_res_d = a_raw_q;
            lo_res_d = {WIDTH{1'b1}};
            dbz_d    = 1'b1;
        end else begin
            if (!op_q[0] && (sign_a_q ^ sign_b_q)) begin
                lo_res_d = -acc_q[WIDTH-1:0];
            end
            if (!op_q[0] && sign_a_q) begin
                hi_res_d = -acc_q[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= 2'b00;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_raw_q  <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dbz_q <= 1'b0;
                    if (start) begin
                        op_q     <= op;
                        sign_a_q <= a_neg;
                        sign_b_q <= b_neg;
                        a_raw_q  <= srcA;
                        b_q      <= b_mag;
                        acc_q    <= {{WIDTH{1'b0}}, a_mag};
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        if (!op[1]) begin
                            acc_q   <= fast_prod;
                            state_q <= S_FIX;
                        end else begin
                            state_q <= S_CALC;
                        end
`else
                        state_q  <= S_CALC;
`endif
                    end else begin
                        if (hiWrite) hi_q <= wdata;
                        if (loWrite) lo_q <= wdata;
                    end
                end
                S_CALC: begin
                    acc_q <= op_q[1] ? div_step_d : mul_step_d;
                    if (cnt_q == C_LAST_STEP) begin
                        cnt_q   <= '0;
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_res_d;
                    lo_q    <= lo_res_d;
                    dbz_q   <= dbz_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign divByZero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Randomized self-checking bench for muldiv_unit (WIDTH=32).
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        hiWrite;
    logic        loWrite;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divByZero;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .srcA      (srcA),
        .srcB      (srcB),
        .hiWrite   (hiWrite),
        .loWrite   (loWrite),
        .wdata     (wdata),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Reference model: {dbz, hi, lo} from plain MIPS arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic [63:0]        p;
        int                 si;
        int                 sj;
        case (o)
            2'b00: begin
                sa64 = {{32{a[31]}}, a};
                sb64 = {{32{b[31]}}, b};
                p = sa64 * sb64;
                return {1'b0, p};
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
                si = a;
                sj = b;
                return {1'b0, 32'(si % sj), 32'(si / sj)};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Launch one op and follow it to commit. inj: start/MTHI/MTLO mid-flight;
    // wr: MTHI/MTLO in the same cycle as start.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inj, input bit wr, input string tag);
        logic [64:0] exp;
        int          n;
        int          exp_len;
        exp = model(o, a, b);
        exp_len = (FAST && !o[1]) ? 1 : 33;
        @(negedge clk);
        op = o; srcA = a; srcB = b; start = 1'b1;
        if (wr) begin
            hiWrite = 1'b1; loWrite = 1'b1; wdata = $urandom;
        end
        @(negedge clk);
        start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 2) begin
                check({tag, "_hold_hi"}, {32'd0, hi}, {32'd0, hi_m});
                check({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, lo_m});
            end
            if (inj && n == 3) begin
                start = 1'b1; hiWrite = 1'b1; loWrite = 1'b1;
                wdata = 32'hDEAD_BEEF; srcA = $urandom; srcB = $urandom; op = 2'($urandom);
            end else begin
                start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
        check({tag, "_busylen"}, 64'(n), 64'(exp_len));
        check({tag, "_hilo"}, {hi, lo}, exp[63:0]);
        check({tag, "_dbz"}, {63'd0, divByZero}, {63'd0, exp[64]});
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        @(negedge clk);
        check({tag, "_dbz_clr"}, {63'd0, divByZero}, 64'd0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
        hiWrite = 1'b0; loWrite = 1'b0; wdata = '0;
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_dbz", {63'd0, divByZero}, 64'd0);
        rst = 1'b0;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, "mult_neg");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_neg");
        run_op(2'b11, 32'd100, 32'd7, 0, 0, "divu");
        run_op(2'b11, 32'd7, 32'd0, 0, 0, "divu_zero");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0, 0, "div_zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");

        // Idle MTLO, then MTHI+MTLO together.
        @(negedge clk);
        loWrite = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        loWrite = 1'b0;
        lo_m = 32'h1234;
        check("mtlo", {32'd0, lo}, 64'h1234);
        check("mtlo_hi_keep", {32'd0, hi}, {32'd0, hi_m});
        hiWrite = 1'b1; loWrite = 1'b1; wdata = 32'hCAFE_0001;
        @(negedge clk);
        hiWrite = 1'b0; loWrite = 1'b0;
        hi_m = 32'hCAFE_0001; lo_m = 32'hCAFE_0001;
        check("mthi_mtlo", {hi, lo}, {hi_m, lo_m});

        run_op(2'b11, 32'd1000, 32'd3, 1, 0, "inject");
        run_op(2'b10, 32'h7FFF_0000, 32'hFFFF_FF00, 0, 1, "start_wr");

        // Reset at busy cycle 10 aborts the op.
        @(negedge clk);
        op = 2'b11; srcA = 32'd50; srcB = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        hi_m = '0; lo_m = '0;
        repeat (40) @(negedge clk);
        check("no_commit", {31'd0, busy, hi, lo}, 64'd0);
        run_op(2'b01, 32'd12345, 32'd678, 0, 0, "post_rst");

        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom), pick_val(), pick_val(), 0, 0, "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle HI/LO multiply/divide unit; the execution extension of the single-cycle datapath for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- Parametrised in operand width.
- Stalls the datapath through `busy` while an operation iterates, then commits the result to the architectural HI/LO registers.

Parameters:
- WIDTH, 32, operand/HI/LO width (even, >=4)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  launch operation (sampled only when idle)
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- srcA  input  WIDTH  rs operand (multiplicand/dividend)
- srcB  input  WIDTH  rt operand (multiplier/divisor)
- hiWrite  input  1  MTHI strobe
- loWrite  input  1  MTLO strobe
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in flight; datapath must stall HI/LO readers
- hi  output  WIDTH  HI register (MFHI source)
- lo  output  WIDTH  LO register (MFLO source)
- divByZero  output  1  one-cycle pulse at commit of a divide with srcB==0

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, hi=0, lo=0, divByZero=0, counter=0; any in-flight operation is aborted with no commit.
- FSM states:
  - IDLE: start=1 at edge E0 -> CALC; op, |srcA|, |srcB| and the sign bits are captured (magnitudes only for the signed ops MULT/DIV).
  - CALC: counter runs 0..WIDTH-1, one radix-2 step per edge (shift-add multiply, restoring divide) at E1..E_WIDTH; after step WIDTH-1 -> FIX.
  - FIX: sign correction and HI/LO commit at E_{WIDTH+1} -> IDLE.
- busy=1 from E0 until E_{WIDTH+1}, i.e. WIDTH+1 cycles; hi/lo hold their old values until commit.
- Multiply: {hi,lo} = full 2*WIDTH product.
  - MULT: product negated if signA^signB.
  - MULTU: unsigned.
- Divide: lo=quotient, hi=remainder (truncating).
  - Quotient sign = signA^signB; remainder sign = signA (DIV only).
- Boundary cases:
  - Divide by zero (DIV or DIVU): lo={WIDTH{1'b1}}, hi=srcA as captured; divByZero=1 for exactly the commit cycle.
  - DIV of most-negative by -1: lo=most-negative, hi=0; no flag.
  - start while busy: ignored, no queuing.
  - hiWrite/loWrite while busy: ignored.
  - hiWrite/loWrite while IDLE: register := wdata at the same edge; both may be asserted together.
  - start and hiWrite/loWrite in the same IDLE cycle: start taken, writes dropped.
  - Back-to-back: start may be asserted in the cycle after commit (busy=0), so the new E0 is E_{WIDTH+2}.
- Outputs are registered; no combinational path from any input to busy/hi/lo.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle combinational multiplier: captured at E0, committed at E1, busy=1 for exactly one cycle.
  - Divide is unchanged.
- Undefined:
  - All ops iterate as above, WIDTH+1 busy cycles.
- divByZero and reset behaviour are identical in both builds.

Test Plan (WIDTH=32, macro undefined unless stated):
- MULTU srcA=0xFFFFFFFF srcB=0xFFFFFFFF -> busy high 33 cycles, then hi=0xFFFFFFFE lo=0x00000001.
- MULT srcA=0xFFFFFFFD (-3) srcB=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; then with MULDIV_FAST_MUL_EN defined, same result with busy for 1 cycle.
- DIV srcA=0xFFFFFFF9 (-7) srcB=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU srcA=100 srcB=7 -> lo=14 hi=2.
- DIVU srcA=7 srcB=0 -> lo=0xFFFFFFFF hi=7, divByZero single pulse at commit; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0, no flag.
- Idle loWrite wdata=0x1234 -> lo=0x1234 next edge; hiWrite and a second start during busy -> hi unchanged and busy length unchanged (33 cycles).
- Assert rst at busy cycle 10 -> busy=0 hi=0 lo=0 immediately; no later commit; new start after reset release completes normally.
